// File: rtl/fpnew_divsqrt_iter_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpnew_divsqrt_iter_unit_pkg
// Brief   : Shared types and helpers for the iterative divsqrt mantissa engine.
// Revision: 1.0 - initial release
// ============================================================================
package fpnew_divsqrt_iter_unit_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } divsqrt_state_e;

    function automatic int unsigned man_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 52;
        endcase
    endfunction

    // Hidden bit plus guard and round bits on top of the stored mantissa.
    function automatic int unsigned divsqrt_num_iter(input fp_format_e fmt);
        return man_bits(fmt) + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_divsqrt_iter_step.sv
`default_nettype none
// ============================================================================
// Module  : fpnew_divsqrt_iter_step
// Brief   : One combinational radix-2 restoring step shared by div and sqrt.
// Revision: 1.0 - initial release
// ============================================================================
module fpnew_divsqrt_iter_step
    import fpnew_divsqrt_iter_unit_pkg::*;
#(
    parameter  int unsigned MANT_WIDTH = 53,
    localparam int unsigned RES_WIDTH  = MANT_WIDTH + 2,
    localparam int unsigned REM_WIDTH  = RES_WIDTH + 2
) (
    input  logic                  i_sqrt,
    input  logic [REM_WIDTH-1:0]  i_rem,
    input  logic [RES_WIDTH-1:0]  i_root,
    input  logic [MANT_WIDTH-1:0] i_divisor,
    input  logic [1:0]            i_pair,
    output logic [REM_WIDTH-1:0]  o_rem,
    output logic                  o_digit
);

    logic [REM_WIDTH-1:0] w_rem_sh;
    logic [REM_WIDTH-1:0] w_sub;
    logic [REM_WIDTH-1:0] w_sel;
    logic [REM_WIDTH:0]   w_diff;

    // Sqrt brings in the next radicand bit pair and trials 4Q+1; div trials B
    // and doubles the remainder afterwards so it is ready for the next bit.
    always_comb begin
        w_rem_sh = i_sqrt ? {i_rem[REM_WIDTH-3:0], i_pair} : i_rem;
        w_sub    = i_sqrt ? {i_root, 2'b01} : REM_WIDTH'(i_divisor);
        w_diff   = {1'b0, w_rem_sh} - {1'b0, w_sub};
        o_digit  = ~w_diff[REM_WIDTH];
        w_sel    = o_digit ? w_diff[REM_WIDTH-1:0] : w_rem_sh;
        o_rem    = i_sqrt ? w_sel : {w_sel[REM_WIDTH-2:0], 1'b0};
    end

endmodule
`default_nettype wire

// File: rtl/fpnew_divsqrt_iter_unit.sv
`default_nettype none
// ============================================================================
// Module  : fpnew_divsqrt_iter_unit
// Brief   : Radix-2 iterative mantissa divider / square root, one bit per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module fpnew_divsqrt_iter_unit
    import fpnew_divsqrt_iter_unit_pkg::*;
#(
    parameter  int unsigned MANT_WIDTH = 53,
    localparam int unsigned RES_WIDTH  = MANT_WIDTH + 2,
    localparam int unsigned CNT_WIDTH  = $clog2(RES_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  div_start_i,
    input  logic                  sqrt_start_i,
    input  logic [MANT_WIDTH-1:0] mant_a_i,
    input  logic [MANT_WIDTH-1:0] mant_b_i,
    input  logic                  exp_odd_i,
    input  logic [CNT_WIDTH-1:0]  num_iter_i,
    input  logic                  kill_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [RES_WIDTH-1:0]  result_o,
    output logic                  sticky_o
);

    localparam int unsigned REM_WIDTH = RES_WIDTH + 2;
    // Radicand fraction is padded to an even bit count so it splits into pairs.
    localparam int unsigned RAD_PAD   = (MANT_WIDTH - 1) % 2;
    localparam int unsigned RAD_WIDTH = MANT_WIDTH + 1 + RAD_PAD;
    localparam logic [CNT_WIDTH-1:0] C_MAX_ITER = CNT_WIDTH'(RES_WIDTH);
    localparam logic [CNT_WIDTH-1:0] C_ONE      = CNT_WIDTH'(1);

    divsqrt_state_e        r_state;
    divsqrt_state_e        w_state_next;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_n_clamp;
    logic                  r_sqrt;
    logic [REM_WIDTH-1:0]  r_rem;
    logic [REM_WIDTH-1:0]  w_rem_next;
    logic [RAD_WIDTH-1:0]  r_rad;
    logic [RAD_WIDTH-1:0]  w_rad_next;
    logic [RAD_WIDTH-1:0]  w_radicand;
    logic [MANT_WIDTH-1:0] r_divisor;
    logic [RES_WIDTH-1:0]  r_res;
    logic                  r_sticky;
    logic                  w_digit;
    logic                  w_accept;
    logic                  w_last;

    assign ready_o  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign done_o   = (r_state == S_DONE);
    assign result_o = r_res;
    assign sticky_o = r_sticky;

    assign w_accept   = ready_o & (div_start_i | sqrt_start_i) & ~kill_i;
    assign w_last     = (r_state == S_BUSY) && (r_cnt == C_ONE);
    assign w_rad_next = r_rad << 2;
    assign w_radicand = RAD_WIDTH'(exp_odd_i ? {mant_a_i, 1'b0} : {1'b0, mant_a_i}) << RAD_PAD;

    always_comb begin
        w_n_clamp = num_iter_i;
        if (num_iter_i == '0) begin
            w_n_clamp = C_ONE;
        end else if (num_iter_i > C_MAX_ITER) begin
            w_n_clamp = C_MAX_ITER;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_BUSY;
            S_BUSY:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = w_accept ? S_BUSY : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (kill_i) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    fpnew_divsqrt_iter_step #(
        .MANT_WIDTH (MANT_WIDTH)
    ) u_step (
        .i_sqrt    (r_sqrt),
        .i_rem     (r_rem),
        .i_root    (r_res),
        .i_divisor (r_divisor),
        .i_pair    (r_rad[RAD_WIDTH-1 -: 2]),
        .o_rem     (w_rem_next),
        .o_digit   (w_digit)
    );

    // Result bits shift in MSB first; r_res doubles as the partial root.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_sqrt    <= 1'b0;
            r_rem     <= '0;
            r_rad     <= '0;
            r_divisor <= '0;
            r_res     <= '0;
            r_sticky  <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= w_n_clamp;
            r_sqrt    <= sqrt_start_i & ~div_start_i;
            r_rem     <= div_start_i ? REM_WIDTH'(mant_a_i) : '0;
            r_rad     <= div_start_i ? '0 : w_radicand;
            r_divisor <= mant_b_i;
            r_res     <= '0;
            r_sticky  <= 1'b0;
        end else if ((r_state == S_BUSY) && !kill_i) begin
            r_cnt <= r_cnt - C_ONE;
            r_rem <= w_rem_next;
            r_rad <= w_rad_next;
            r_res <= {r_res[RES_WIDTH-2:0], w_digit};
            // Unconsumed radicand bits also make a root inexact.
            if (w_last) begin
                r_sticky <= (w_rem_next != '0) | (r_sqrt & (w_rad_next != '0));
            end
        end
    end

endmodule
`default_nettype wire
